// File: rtl/pipeline_flow_ctrl_if.sv
// Handshake bundle between the hazard/stall sources and the pipeline flow controller.
// Master drives the requests; slave (the controller) returns the enables, clears and status.
interface pipeline_flow_ctrl_if #(
  parameter int NR = 4
);
  logic          load_hazard_i;
  logic          branch_taken_i;
  logic          stall_req_i;
  logic          flush_req_i;
  logic          timeout_clr_i;
  logic          pc_en_o;
  logic [NR-1:0] reg_en_o;
  logic [NR-1:0] reg_clr_o;
  logic [NR-1:0] valid_o;
  logic          timeout_o;
  logic [31:0]   bubble_cnt_o;

  modport master (
    output load_hazard_i, branch_taken_i, stall_req_i, flush_req_i, timeout_clr_i,
    input  pc_en_o, reg_en_o, reg_clr_o, valid_o, timeout_o, bubble_cnt_o
  );

  modport slave (
    input  load_hazard_i, branch_taken_i, stall_req_i, flush_req_i, timeout_clr_i,
    output pc_en_o, reg_en_o, reg_clr_o, valid_o, timeout_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller: turns flush/stall/branch/load-use requests into per-register
// enables and clears, tracks valid bits, times out long external stalls and counts bubbles.
module pipeline_flow_ctrl #(
  parameter int NUM_STAGES       = 5,
  parameter int BRANCH_RES_STAGE = 3,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int STALL_TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_flow_ctrl_if.slave   bus
);
  localparam int NR = NUM_STAGES - 1;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_LU  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    lu_cnt_q, lu_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   bubble_cnt_q, bubble_cnt_d;
  logic [NR-1:0] valid_q, valid_d;
  logic          pc_en_prev_q;

  logic          flush_ev, stall_ev, branch_ev, lu_ev;
  logic          pc_en;
  logic [NR-1:0] reg_en, reg_clr;
  logic [NR-1:0] br_mask;
  logic          timeout_set;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_br_mask
      assign br_mask[gi] = (gi < BRANCH_RES_STAGE);
    end
  endgenerate

  // Strict priority: flush > external stall > taken branch > load-use bubble.
  assign flush_ev  = bus.flush_req_i;
  assign stall_ev  = !flush_ev && bus.stall_req_i;
  assign branch_ev = !flush_ev && !stall_ev && bus.branch_taken_i;
  assign lu_ev     = !flush_ev && !stall_ev && !branch_ev &&
                     ((state_q == ST_LU) || bus.load_hazard_i);

  always_comb begin
    pc_en    = 1'b1;
    reg_en   = '1;
    reg_clr  = '0;
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (flush_ev) begin
      reg_clr  = '1;
      state_d  = ST_RUN;
      lu_cnt_d = '0;
    end else if (stall_ev) begin
      pc_en  = 1'b0;
      reg_en = '0;
    end else if (branch_ev) begin
      reg_clr  = br_mask;
      state_d  = ST_RUN;
      lu_cnt_d = '0;
    end else if (lu_ev) begin
      pc_en      = 1'b0;
      reg_en[0]  = 1'b0;
      reg_clr[1] = 1'b1;
      if (state_q == ST_LU) begin
        if (lu_cnt_q == 3'd1) begin
          state_d  = ST_RUN;
          lu_cnt_d = '0;
        end else begin
          lu_cnt_d = lu_cnt_q - 3'd1;
        end
      end else if (LOAD_USE_BUBBLES > 1) begin
        // Detection cycle already counts as the first bubble.
        state_d  = ST_LU;
        lu_cnt_d = 3'(LOAD_USE_BUBBLES - 1);
      end
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall_ev) begin
      stall_cnt_d = (stall_cnt_q == 16'(STALL_TIMEOUT)) ? stall_cnt_q : stall_cnt_q + 16'd1;
    end
  end

  assign timeout_set  = stall_ev && (stall_cnt_d == 16'(STALL_TIMEOUT));
  assign timeout_d    = timeout_set || (timeout_q && !bus.timeout_clr_i);
  assign bubble_cnt_d = bubble_cnt_q + ((!pc_en || (|reg_clr)) ? 32'd1 : 32'd0);

  generate
    for (gi = 0; gi < NR; gi++) begin : g_valid
      logic src;
      if (gi == 0) begin : g_src_pc
        assign src = pc_en_prev_q;
      end else begin : g_src_reg
        assign src = valid_q[gi-1];
      end
      assign valid_d[gi] = reg_clr[gi] ? 1'b0 : (reg_en[gi] ? src : valid_q[gi]);
    end
  endgenerate

  // The PC is enabled while reset is held, so the first fetched slot counts as valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      lu_cnt_q     <= '0;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      bubble_cnt_q <= '0;
      valid_q      <= '0;
      pc_en_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lu_cnt_q     <= lu_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
      bubble_cnt_q <= bubble_cnt_d;
      valid_q      <= valid_d;
      pc_en_prev_q <= pc_en;
    end
  end

  assign bus.pc_en_o      = pc_en;
  assign bus.reg_en_o     = reg_en;
  assign bus.reg_clr_o    = reg_clr;
  assign bus.valid_o      = valid_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;
endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Testbench for pipeline_flow_ctrl: bubble-count model checked every cycle plus directed
// literal expectations (NUM_STAGES=5, BRANCH_RES_STAGE=3, LOAD_USE_BUBBLES=2, STALL_TIMEOUT=255).
module tb_pipeline_flow_ctrl;
  localparam int NR  = 4;
  localparam int BRS = 3;
  localparam int LUB = 2;
  localparam int TO  = 255;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_err;

  pipeline_flow_ctrl_if #(.NR(NR)) bus ();

  pipeline_flow_ctrl #(
    .NUM_STAGES       (NR + 1),
    .BRANCH_RES_STAGE (BRS),
    .LOAD_USE_BUBBLES (LUB),
    .STALL_TIMEOUT    (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: remaining forced load-use bubbles, plain valid shift, stall run length.
  int          m_left;
  logic [3:0]  m_valid;
  logic        m_prev_pc;
  int          m_run;
  logic        m_to;
  logic [31:0] m_bub;

  always @(negedge clk) begin : monitor
    logic       e_pc;
    logic [3:0] e_en, e_clr, nv, src;
    logic       is_stall;
    if (!reset_n) begin
      m_left = 0; m_valid = '0; m_prev_pc = 1'b1; m_run = 0; m_to = 1'b0; m_bub = '0;
      check("rst_pc_en", {31'd0, bus.pc_en_o}, 32'd1);
      check("rst_reg_en", {28'd0, bus.reg_en_o}, 32'hF);
      check("rst_reg_clr", {28'd0, bus.reg_clr_o}, 32'h0);
      check("rst_valid", {28'd0, bus.valid_o}, 32'h0);
      check("rst_bubble", bus.bubble_cnt_o, 32'h0);
    end else begin
      e_pc = 1'b1; e_en = 4'hF; e_clr = 4'h0; is_stall = 1'b0;
      if (bus.flush_req_i) begin
        e_clr = 4'hF; m_left = 0;
      end else if (bus.stall_req_i) begin
        e_pc = 1'b0; e_en = 4'h0; is_stall = 1'b1;
      end else if (bus.branch_taken_i) begin
        e_clr = 4'((1 << BRS) - 1); m_left = 0;
      end else if (m_left > 0 || bus.load_hazard_i) begin
        e_pc = 1'b0; e_en = 4'b1110; e_clr = 4'b0010;
        m_left = (m_left > 0) ? m_left - 1 : LUB - 1;
      end
      check("pc_en", {31'd0, bus.pc_en_o}, {31'd0, e_pc});
      check("reg_en", {28'd0, bus.reg_en_o}, {28'd0, e_en});
      check("reg_clr", {28'd0, bus.reg_clr_o}, {28'd0, e_clr});
      check("valid", {28'd0, bus.valid_o}, {28'd0, m_valid});
      check("timeout", {31'd0, bus.timeout_o}, {31'd0, m_to});
      check("bubble_cnt", bus.bubble_cnt_o, m_bub);
      src = {m_valid[2:0], m_prev_pc};
      nv  = (m_valid & ~e_en) | (src & e_en);
      m_valid   = nv & ~e_clr;
      m_prev_pc = e_pc;
      if (!e_pc || e_clr != 0) m_bub = m_bub + 1;
      m_run = is_stall ? m_run + 1 : 0;
      if (is_stall && m_run >= TO) m_to = 1'b1;
      else if (bus.timeout_clr_i)  m_to = 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fill [4];

  initial begin
    n_checks = 0;
    n_err    = 0;
    fill[0] = 4'b0001; fill[1] = 4'b0011; fill[2] = 4'b0111; fill[3] = 4'b1111;
    reset_n = 1'b0;
    bus.load_hazard_i = 0; bus.branch_taken_i = 0; bus.stall_req_i = 0;
    bus.flush_req_i = 0; bus.timeout_clr_i = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset, then valid fills one stage per cycle.
    @(negedge clk);
    check("lit_idle_pc", {31'd0, bus.pc_en_o}, 32'd1);
    check("lit_idle_en", {28'd0, bus.reg_en_o}, 32'hF);
    check("lit_idle_clr", {28'd0, bus.reg_clr_o}, 32'h0);
    check("lit_idle_valid", {28'd0, bus.valid_o}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lit_fill", {28'd0, bus.valid_o}, {28'd0, fill[k]});
    end
    $display("txn: reset and valid fill done");

    // Single-cycle load-use hazard gives two bubbles.
    next_cycle(); bus.load_hazard_i = 1;
    @(negedge clk);
    check("lit_lu1_pc", {31'd0, bus.pc_en_o}, 32'd0);
    check("lit_lu1_clr", {28'd0, bus.reg_clr_o}, 32'h2);
    check("lit_lu1_en", {28'd0, bus.reg_en_o}, 32'hE);
    next_cycle(); bus.load_hazard_i = 0;
    @(negedge clk);
    check("lit_lu2_pc", {31'd0, bus.pc_en_o}, 32'd0);
    check("lit_lu2_clr", {28'd0, bus.reg_clr_o}, 32'h2);
    next_cycle();
    @(negedge clk);
    check("lit_lu_done_pc", {31'd0, bus.pc_en_o}, 32'd1);
    check("lit_lu_bubbles", bus.bubble_cnt_o, 32'd2);
    $display("txn: load-use hazard, bubble_cnt=%0d", bus.bubble_cnt_o);

    // Taken branch during the load-use stall.
    next_cycle(); bus.load_hazard_i = 1;
    next_cycle(); bus.load_hazard_i = 0; bus.branch_taken_i = 1;
    @(negedge clk);
    check("lit_br_clr", {28'd0, bus.reg_clr_o}, 32'h7);
    check("lit_br_pc", {31'd0, bus.pc_en_o}, 32'd1);
    next_cycle(); bus.branch_taken_i = 0;
    @(negedge clk);
    check("lit_br_run_clr", {28'd0, bus.reg_clr_o}, 32'h0);
    check("lit_br_run_pc", {31'd0, bus.pc_en_o}, 32'd1);
    check("lit_br_bubbles", bus.bubble_cnt_o, 32'd4);
    $display("txn: branch in LU_STALL, bubble_cnt=%0d", bus.bubble_cnt_o);

    // 300-cycle external stall with timeout.
    next_cycle(); bus.stall_req_i = 1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("lit_stall_pc", {31'd0, bus.pc_en_o}, 32'd0);
        check("lit_stall_en", {28'd0, bus.reg_en_o}, 32'h0);
      end
      if (k == 254) check("lit_to_early", {31'd0, bus.timeout_o}, 32'd0);
      if (k == 256) check("lit_to_set", {31'd0, bus.timeout_o}, 32'd1);
      if (k < 300) next_cycle();
    end
    next_cycle(); bus.stall_req_i = 0;
    @(negedge clk);
    check("lit_to_sticky", {31'd0, bus.timeout_o}, 32'd1);
    check("lit_stall_bubbles", bus.bubble_cnt_o, 32'd304);
    next_cycle(); bus.timeout_clr_i = 1;
    next_cycle(); bus.timeout_clr_i = 0;
    @(negedge clk);
    check("lit_to_clr", {31'd0, bus.timeout_o}, 32'd0);
    $display("txn: 300-cycle stall, timeout cleared, bubble_cnt=%0d", bus.bubble_cnt_o);

    // Flush beats simultaneous stall and branch.
    next_cycle(); bus.flush_req_i = 1; bus.stall_req_i = 1; bus.branch_taken_i = 1;
    @(negedge clk);
    check("lit_fl_clr", {28'd0, bus.reg_clr_o}, 32'hF);
    check("lit_fl_pc", {31'd0, bus.pc_en_o}, 32'd1);
    check("lit_fl_en", {28'd0, bus.reg_en_o}, 32'hF);
    next_cycle(); bus.flush_req_i = 0; bus.stall_req_i = 0; bus.branch_taken_i = 0;
    @(negedge clk);
    check("lit_fl_valid", {28'd0, bus.valid_o}, 32'h0);
    check("lit_fl_bubbles", bus.bubble_cnt_o, 32'd305);
    $display("txn: flush with stall and branch, valid=%b", bus.valid_o);

    // Async reset in the middle of LU_STALL.
    next_cycle(); bus.load_hazard_i = 1;
    next_cycle(); bus.load_hazard_i = 0;
    #2 reset_n = 1'b0;
    #1;
    check("lit_ar_pc", {31'd0, bus.pc_en_o}, 32'd1);
    check("lit_ar_en", {28'd0, bus.reg_en_o}, 32'hF);
    check("lit_ar_clr", {28'd0, bus.reg_clr_o}, 32'h0);
    check("lit_ar_bubbles", bus.bubble_cnt_o, 32'd0);
    check("lit_ar_valid", {28'd0, bus.valid_o}, 32'h0);
    check("lit_ar_timeout", {31'd0, bus.timeout_o}, 32'd0);
    @(negedge clk);
    next_cycle(); reset_n = 1'b1;
    repeat (6) next_cycle();
    @(negedge clk);
    check("lit_ar_refill", {28'd0, bus.valid_o}, 32'hF);
    check("lit_ar_run_pc", {31'd0, bus.pc_en_o}, 32'd1);
    $display("txn: async reset mid LU_STALL, refill valid=%b", bus.valid_o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
